// File: rtl/add16_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// add16_arbiter_pkg
// Shared definitions for the Add16 arbiter slice: datapath word width, the
// arbiter FSM state encoding and the wrap-around add used by the Add16 unit.
// No ports (package).
// -----------------------------------------------------------------------------
package add16_arbiter_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  // Plain modulo-2^16 add: the carry out is intentionally dropped.
  function automatic word_t add16_wrap(input word_t a, input word_t b);
    return a + b;
  endfunction

endpackage

// File: rtl/add16_arbiter_if.sv
// -----------------------------------------------------------------------------
// add16_arbiter_if
// Request/response bundle between NUM_REQ requesters, the arbiter and the
// result consumer.
//   req_valid  [NUM_REQ]         requester i presents operands
//   req_a/b    [NUM_REQ*16]      operands, requester i at [16*i +: 16]
//   req_ready  [NUM_REQ]         one-hot or zero, requester i accepted
//   resp_valid / resp_ready      result handshake
//   resp_data  [16]              a + b mod 2^16
//   resp_id    [IDX_W]           requester that produced resp_data
//   busy                         resp_valid | any req_valid
// Modports: slave = arbiter side, master = requesters/consumer side.
// -----------------------------------------------------------------------------
interface add16_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import add16_arbiter_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*WORD_W-1:0] req_a;
  logic [NUM_REQ*WORD_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      resp_valid;
  logic                      resp_ready;
  word_t                     resp_data;
  logic [IDX_W-1:0]          resp_id;
  logic                      busy;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, busy
  );

endinterface

// File: rtl/add16_arbiter_add16.sv
// -----------------------------------------------------------------------------
// add16
// The shared 16-bit adder, purely combinational.
//   a, b  in  16   operands
//   sum   out 16   a + b mod 2^16 (no carry out)
// -----------------------------------------------------------------------------
module add16
  import add16_arbiter_pkg::*;
(
  input  word_t a,
  input  word_t b,
  output word_t sum
);

  assign sum = add16_wrap(a, b);

endmodule

// File: rtl/add16_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority selector. Scans req starting at rr_ptr and
// wrapping at NUM_REQ-1 -> 0; the first set bit wins.
//   req           in  NUM_REQ  request vector
//   rr_ptr        in  IDX_W    highest-priority index this cycle
//   grant_onehot  out NUM_REQ  one-hot winner (zero when no request)
//   grant_idx     out IDX_W    winner index (0 when no request)
//   any           out 1        at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  int               pos;
  logic [IDX_W-1:0] idx;

  // Walk from the lowest priority offset up to offset 0, so the last hit
  // (the one closest to rr_ptr) overrides all earlier ones.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = |req;
    pos          = 0;
    idx          = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      idx = IDX_W'(pos);
      if (req[idx]) begin
        grant_onehot      = '0;
        grant_onehot[idx] = 1'b1;
        grant_idx         = idx;
      end
    end
  end

endmodule

// File: rtl/add16_arbiter.sv
// -----------------------------------------------------------------------------
// add16_arbiter
// Shares one Add16 between NUM_REQ requesters with round-robin grant and a
// registered result stage that sustains one addition per clock under
// resp_ready, and freezes the held result under backpressure.
//   clk    in  1   rising-edge clock
//   rst_n  in  1   asynchronous active-low reset
//   bus    slave modport of add16_arbiter_if (request/response bundle)
// -----------------------------------------------------------------------------
module add16_arbiter
  import add16_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  add16_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("add16_arbiter: NUM_REQ must be in 2..8");
  end

  arb_state_e       state_q, state_d;
  word_t            resp_data_q, resp_data_d;
  logic [IDX_W-1:0] resp_id_q, resp_id_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] grant_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               any_req;
  logic               accept_ok;
  logic               grant;
  word_t              op_a, op_b, sum;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req          (bus.req_valid),
    .rr_ptr       (rr_ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (win_idx),
    .any          (any_req)
  );

  assign op_a = bus.req_a[win_idx*WORD_W +: WORD_W];
  assign op_b = bus.req_b[win_idx*WORD_W +: WORD_W];

  add16 u_add16 (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  // The output slot can take a new result when empty, or when the held one
  // retires on this very edge (no bubble between back-to-back results).
  assign accept_ok     = (state_q == ARB_IDLE) || bus.resp_ready;
  assign grant         = accept_ok && any_req;
  assign bus.req_ready = grant ? grant_onehot : '0;

  always_comb begin
    state_d     = state_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant) begin
      state_d     = ARB_HOLD;
      resp_data_d = sum;
      resp_id_d   = win_idx;
      // Priority moves just past the winner; idle cycles leave it alone.
      rr_ptr_d    = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (state_q == ARB_HOLD && bus.resp_ready) begin
      state_d = ARB_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      resp_data_q <= '0;
      resp_id_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.resp_valid = (state_q == ARB_HOLD);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.busy       = bus.resp_valid || (|bus.req_valid);

endmodule

// File: tb/tb_add16_arbiter.sv
// -----------------------------------------------------------------------------
// tb_add16_arbiter
// Bench for add16_arbiter (NUM_REQ=4). A predictor turns each accepted request
// into an expected {id, sum} pushed on a queue; a monitor pops and compares
// whenever the DUT presents a result. Directed scenarios cover reset, single
// request, 16-bit wrap, round-robin order, backpressure and priority hold,
// followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_add16_arbiter;
  import add16_arbiter_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add16_arbiter_if #(.NUM_REQ(N)) bus();

  add16_arbiter #(.NUM_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0]  drv_a [N];
  logic [15:0]  drv_b [N];
  logic [N-1:0] drv_valid;
  int           auto_cnt [N];
  bit           rand_arrivals;
  bit           rand_ready;
  logic [N-1:0] hs_neg;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: priority pointer and "result slot occupied".
  int m_ptr;
  bit m_hold;

  logic [N-1:0] last_valid, last_hs;
  logic [15:0]  last_a [N];
  logic [15:0]  last_b [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 16'hFFFF;
      1: return 16'h0001;
      2: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic apply();
    bus.req_valid = drv_valid;
    for (int i = 0; i < N; i++) begin
      bus.req_a[16*i +: 16] = drv_a[i];
      bus.req_b[16*i +: 16] = drv_b[i];
    end
  endtask

  // Advance one clock; requesters that handshook reload or drop their request.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_neg[i]) begin
        if (auto_cnt[i] > 0) begin
          auto_cnt[i]--;
          drv_a[i] = rand_op();
          drv_b[i] = rand_op();
        end else begin
          drv_valid[i] = 1'b0;
        end
      end else if (rand_arrivals && !drv_valid[i] && $urandom_range(0, 2) == 0) begin
        drv_valid[i] = 1'b1;
        drv_a[i]     = rand_op();
        drv_b[i]     = rand_op();
      end
    end
    if (rand_ready) bus.resp_ready = ($urandom_range(0, 3) != 0);
    apply();
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    drv_valid[i] = 1'b1;
    drv_a[i]     = a;
    drv_b[i]     = b;
  endtask

  // Monitor: compare the presented result with the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      hs_neg     = '0;
      last_valid = '0;
      last_hs    = '0;
    end else begin
      hs_neg = bus.req_valid & bus.req_ready;
      for (int i = 0; i < N; i++) begin
        if (last_valid[i] && !last_hs[i]) begin
          if (!bus.req_valid[i] || bus.req_a[16*i +: 16] != last_a[i] || bus.req_b[16*i +: 16] != last_b[i])
            $error("requester %0d changed its request before being accepted", i);
        end
        last_a[i] = bus.req_a[16*i +: 16];
        last_b[i] = bus.req_b[16*i +: 16];
      end
      last_valid = bus.req_valid;
      last_hs    = hs_neg;
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected: actual id=%0d data=0x%04h required=no response", bus.resp_id, bus.resp_data);
        end else begin
          check("resp_data", 32'(bus.resp_data), 32'(exp_q[0].data));
          check("resp_id", 32'(bus.resp_id), 32'(exp_q[0].id));
          if (bus.resp_ready) begin
            $display("RESP id=%0d data=0x%04h t=%0t", bus.resp_id, bus.resp_data, $time);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Predictor: decide from the rules which requester (if any) is accepted at
  // the coming edge and what it must produce.
  int           p_win;
  int           p_idx;
  int           p_sum;
  bit           p_accept;
  logic [N-1:0] p_rdy;
  exp_t         p_e;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      m_ptr  = 0;
      m_hold = 1'b0;
      exp_q.delete();
    end else begin
      p_accept = !m_hold || bus.resp_ready;
      p_win    = -1;
      if (p_accept) begin
        for (int k = 0; k < N; k++) begin
          p_idx = (m_ptr + k) % N;
          if (p_win < 0 && bus.req_valid[p_idx]) p_win = p_idx;
        end
      end
      p_rdy = '0;
      if (p_win >= 0) p_rdy[p_win] = 1'b1;
      check("req_ready", 32'(bus.req_ready), 32'(p_rdy));
      check("resp_valid", 32'(bus.resp_valid), 32'(m_hold));
      check("busy", 32'(bus.busy), 32'(m_hold || (|bus.req_valid)));
      if (p_win >= 0) begin
        p_sum  = int'(bus.req_a[16*p_win +: 16]) + int'(bus.req_b[16*p_win +: 16]);
        p_e.id   = 2'(p_win);
        p_e.data = 16'(p_sum % 65536);
        exp_q.push_back(p_e);
        m_ptr  = (p_win + 1) % N;
        m_hold = 1'b1;
      end else if (bus.resp_ready) begin
        m_hold = 1'b0;
      end
    end
  end

  initial begin
    bit drained;
    drv_valid     = '0;
    rand_arrivals = 1'b0;
    rand_ready    = 1'b0;
    for (int i = 0; i < N; i++) begin
      drv_a[i]    = '0;
      drv_b[i]    = '0;
      auto_cnt[i] = 0;
    end
    bus.resp_ready = 1'b0;
    apply();
    repeat (3) step();
    rst_n = 1'b1;

    // Reset mid-HOLD with another request waiting.
    set_req(0, 16'h0011, 16'h0022);
    apply();
    step();
    set_req(2, 16'h0100, 16'h0200);
    apply();
    step();
    step();
    #2;
    rst_n = 1'b0;
    drv_valid = '0;
    apply();
    #1;
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", 32'(bus.resp_data), 32'd0);
    check("rst_resp_id", 32'(bus.resp_id), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    set_req(0, 16'h0001, 16'h0002);
    set_req(2, 16'h0003, 16'h0004);
    bus.resp_ready = 1'b1;
    apply();
    #1;
    check("post_rst_first_grant", 32'(bus.req_ready), 32'h1);
    step();
    step();
    step();

    // Single request.
    set_req(1, 16'h1234, 16'h0101);
    apply();
    #1;
    check("single_ready", 32'(bus.req_ready), 32'h2);
    step();
    #1;
    check("single_valid", 32'(bus.resp_valid), 32'd1);
    check("single_data", 32'(bus.resp_data), 32'h1335);
    check("single_id", 32'(bus.resp_id), 32'd1);
    step();

    // 16-bit wrap.
    set_req(3, 16'hFFFF, 16'h0001);
    apply();
    step();
    #1;
    check("wrap_ffff_data", 32'(bus.resp_data), 32'h0);
    check("wrap_ffff_id", 32'(bus.resp_id), 32'd3);
    set_req(0, 16'h8000, 16'h8000);
    apply();
    step();
    #1;
    check("wrap_8000_data", 32'(bus.resp_data), 32'h0);
    check("wrap_8000_id", 32'(bus.resp_id), 32'd0);
    step();

    // Priority hold: after req0, req3 wins; then req0 beats req1 after wrap.
    set_req(3, 16'h0030, 16'h0003);
    apply();
    #1;
    check("prio_req3_ready", 32'(bus.req_ready), 32'h8);
    step();
    set_req(0, 16'h0A00, 16'h00A0);
    set_req(1, 16'h0B00, 16'h00B0);
    apply();
    #1;
    check("prio_wrap_ready", 32'(bus.req_ready), 32'h1);
    step();
    step();
    step();

    // Round-robin: all four continuously valid; pointer sits at 2 after req1.
    for (int i = 0; i < N; i++) begin
      set_req(i, rand_op(), rand_op());
      auto_cnt[i] = 3;
    end
    apply();
    for (int k = 0; k < 16; k++) begin
      step();
      #1;
      check("rr_valid", 32'(bus.resp_valid), 32'd1);
      check("rr_id", 32'(bus.resp_id), 32'((2 + k) % N));
    end
    step();
    step();

    // Backpressure with req2 waiting.
    set_req(1, 16'h4321, 16'h1111);
    apply();
    step();
    bus.resp_ready = 1'b0;
    set_req(2, 16'h0F0F, 16'h1010);
    apply();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_req_ready", 32'(bus.req_ready), 32'h0);
      check("bp_data", 32'(bus.resp_data), 32'h5432);
      check("bp_id", 32'(bus.resp_id), 32'd1);
      step();
    end
    bus.resp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.req_ready), 32'h4);
    step();
    #1;
    check("bp_new_valid", 32'(bus.resp_valid), 32'd1);
    check("bp_new_data", 32'(bus.resp_data), 32'h1F1F);
    check("bp_new_id", 32'(bus.resp_id), 32'd2);
    step();

    // Randomized traffic with random backpressure.
    rand_arrivals = 1'b1;
    rand_ready    = 1'b1;
    repeat (400) step();
    rand_arrivals  = 1'b0;
    rand_ready     = 1'b0;
    bus.resp_ready = 1'b1;
    drained = 1'b0;
    for (int k = 0; k < 60 && !drained; k++) begin
      step();
      #1;
      if (!bus.busy && drv_valid == '0) drained = 1'b1;
    end
    check("drain_done", 32'(drained), 32'd1);
    @(negedge clk);
    #2;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
